clockdiv_prog: RTL and testbench
================================

# clockdiv_prog

Runtime-programmable clock divider, the successor to the fixed-parameter `clockdiv`. It divides `clkin` by an integer N in the range 2..2^W-1, where N can be reloaded while the divider runs. A new divisor takes effect glitch-free at a period boundary and is acknowledged. The block also emits a one-cycle `tick` strobe for logic that stays in the `clkin` domain, and can optionally produce a 50 % duty cycle for odd N.

## Interface
- `W`, 8: divisor width in bits.
- `DIV_INIT`, 2: divisor after reset. Must satisfy 2 ≤ DIV_INIT ≤ 2^W-1.

- `clkin`  in  1: input clock. All logic runs on its rising edge, except the optional falling-edge flop.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: count enable. When 0 the divider freezes.
- `div_in`  in  W: requested divisor.
- `div_ld`  in  1: load strobe, sampled on each rising edge.
- `clkout`  out  1: divided clock.
- `tick`  out  1: one `clkin` cycle high, coincident with each rising edge of `clkout`.
- `cur_div`  out  W: divisor currently in effect.
- `pend`  out  1: a loaded divisor is waiting to be applied.
- `div_ack`  out  1: one-cycle pulse, the cycle after a pending divisor is applied.
- `div_err`  out  1: one-cycle pulse, `div_ld` was seen with `div_in` < 2.

## Operation
**Reset values:**
- cnt = 0, `clkout` = 0, `tick` = 0, `cur_div` = DIV_INIT, `pend` = 0, `div_ack` = 0, `div_err` = 0.
- The pending register and the falling-edge flop are also cleared.

**Counting**, on each rising edge with `en` = 1:
- Wrap condition: cnt == N-1.
- On wrap, cnt_next = 0. Otherwise cnt_next = cnt+1.
- N is the value of `cur_div` before this edge.

**Applying a new divisor:**
- On a wrap edge with `pend` = 1: `cur_div` ← pending value, `pend` ← 0.
- `div_ack` is 1 in the following cycle.

**Outputs (registered):**
- `clkout` ← (cnt_next < H), where H = floor(N'/2) and N' is the divisor in effect after the edge.
- `tick` ← wrap.
- Result: `clkout` rises exactly when `tick` is high, with period N `clkin` cycles.
- High time is H cycles and low time is N-H cycles. For odd N, see Configuration.

**Loads:**
- `div_ld` = 1 with `div_in` ≥ 2: pending ← `div_in`, `pend` ← 1.
- `div_ld` = 1 with `div_in` < 2: the load is ignored and `div_err` pulses. The pending state is unchanged.
- Loads are accepted whether `en` is 0 or 1.

**Boundary cases:**
- A load while `pend` = 1 overwrites the pending value; the last load wins. Only one `div_ack` is produced.
- A load on the same edge as a wrap is stored. It is applied at the next wrap, not the current one.
- Reloading the value already in effect still goes through the pend/ack sequence.
- With `en` = 0, cnt, `clkout`, `cur_div` and `pend` hold, and `tick` is 0. No divisor is applied while `en` = 0.
- `rst` asserted mid-period forces all reset values immediately, whatever the state of `clkin`. Any pending divisor is discarded.

## Timing
- Start-up: after `rst` falls with `en` = 1 and N = 2, the first `tick` and `clkout` rise occur on the 2nd rising edge. In general they occur on the Nth rising edge.
- Load to apply: between 1 and N+1 edges after `div_ld`. The next period after the apply uses the new N.
- `div_ack` and `div_err` are registered, with one edge of latency.
- `clkout` is driven from a register, so it has no combinational glitches. It is intended as a slow clock or clock enable; it must not be routed onto a global clock without review.

## Configuration
Macro `CLKDIV_ODD50_EN`:
- **Defined:** adds a falling-edge flop that samples the registered `clkout`.
  - For odd `cur_div`, `clkout` = registered OR falling-edge copy, giving N/2 cycles high and N/2 cycles low (50 % duty).
  - For even `cur_div`, `clkout` is the registered value only.
  - The flop resets to 0.
  - `tick` is unaffected.
- **Not defined:** no falling-edge logic is built. For odd N the high time is floor(N/2) cycles.

## Test plan
Clock `clkin` at 100 ns period (50 ns half-period) for all scenarios.
1. **Reset and fixed divisor:** DIV_INIT = 2, `rst` high for 120 ns, `en` = 1 → `clkout` period 200 ns, `tick` every 2nd edge, `cur_div` = 2.
2. **Live reload:** N = 4; pulse `div_ld` with `div_in` = 6 at cnt = 1 → `pend` = 1 until the next wrap. `div_ack` pulses the cycle after that wrap, and the next period is 600 ns high/low 300/300 ns.
3. **Invalid load and overwrite:**
   - Load `div_in` = 1 → `div_err` pulse; `pend` and `cur_div` unchanged.
   - Then load 5 and then 7 within one period → only 7 is applied, with a single `div_ack`.
4. **Odd divisor duty:** N = 3.
   - Without `CLKDIV_ODD50_EN` → 100 ns high / 200 ns low.
   - With `CLKDIV_ODD50_EN` → 150 ns high / 150 ns low.
5. **Enable and async reset:**
   - Drop `en` for 3 cycles mid-period → `clkout` holds, `tick` = 0, counting resumes from the held cnt.
   - Assert `rst` for 30 ns between edges with a load pending → all outputs reach reset values immediately, and `cur_div` = DIV_INIT.

Source files
------------

// File: rtl/clockdiv_prog.sv
// clockdiv_prog: runtime-programmable clock divider with tick strobe.
// Optional 50% duty for odd divisors when CLKDIV_ODD50_EN is defined.
module clockdiv_prog #(
    parameter int W        = 8,
    parameter int DIV_INIT = 2
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_ld,
    output logic         clkout,
    output logic         tick,
    output logic [W-1:0] cur_div,
    output logic         pend,
    output logic         div_ack,
    output logic         div_err
);

    localparam logic [W-1:0] DIV_RST = W'(DIV_INIT);
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TWO     = W'(2);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_q, cur_d;
    logic [W-1:0] pdiv_q, pdiv_d;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         wrap;
    logic         apply;
    logic         ld_ok;

    // next-state: counter, divisor hand-over, load capture, outputs
    always_comb begin
        wrap   = en && (cnt_q == (cur_q - ONE));
        apply  = wrap && pend_q;
        ld_ok  = div_ld && (div_in >= TWO);
        cnt_d  = cnt_q;
        cur_d  = cur_q;
        clk_d  = clk_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            if (apply) begin
                cur_d = pdiv_q;
            end
            clk_d = (cnt_d < (cur_d >> 1));
        end
        // a load on the apply edge is kept for the following wrap
        if (apply) begin
            pend_d = 1'b0;
        end
        if (ld_ok) begin
            pdiv_d = div_in;
            pend_d = 1'b1;
        end
        tick_d = wrap;
        ack_d  = apply;
        err_d  = div_ld && (div_in < TWO);
    end

    // state registers
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            cur_q  <= DIV_RST;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

`ifdef CLKDIV_ODD50_EN
    logic fall_q;

    // half-cycle delayed copy stretches the high phase for odd divisors
    always_ff @(negedge clkin or posedge rst) begin
        if (rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= clk_q;
        end
    end

    assign clkout = cur_q[0] ? (clk_q | fall_q) : clk_q;
`else
    assign clkout = clk_q;
`endif

    assign tick    = tick_q;
    assign cur_div = cur_q;
    assign pend    = pend_q;
    assign div_ack = ack_q;
    assign div_err = err_q;

endmodule

// File: tb/tb_clockdiv_prog.sv
// tb_clockdiv_prog: randomized bench for clockdiv_prog against a
// period-position reference model.
`timescale 1ns/1ps
module tb_clockdiv_prog;

    localparam int W        = 8;
    localparam int DIV_INIT = 2;

    logic         clkin = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_ld;
    logic         clkout;
    logic         tick;
    logic [W-1:0] cur_div;
    logic         pend;
    logic         div_ack;
    logic         div_err;

    clockdiv_prog #(.W(W), .DIV_INIT(DIV_INIT)) dut (
        .clkin   (clkin),
        .rst     (rst),
        .en      (en),
        .div_in  (div_in),
        .div_ld  (div_ld),
        .clkout  (clkout),
        .tick    (tick),
        .cur_div (cur_div),
        .pend    (pend),
        .div_ack (div_ack),
        .div_err (div_err)
    );

    always #50 clkin = ~clkin;

    int n_cmp = 0;
    int n_bad = 0;

    // reference: position inside the current period, divisor in force,
    // and the most recent valid request still waiting
    int m_pos;
    int m_n;
    int m_req;
    bit m_has_req;
    bit m_hi;
    bit m_hi_prev;
    bit m_tick;
    bit m_ack;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos     = 0;
        m_n       = DIV_INIT;
        m_req     = 0;
        m_has_req = 0;
        m_hi      = 0;
        m_hi_prev = 0;
        m_tick    = 0;
        m_ack     = 0;
        m_err     = 0;
    endtask

    task automatic model_edge(input bit e, input bit l, input int d);
        bit last;
        bit swap;
        last      = e && (m_pos == m_n - 1);
        swap      = last && m_has_req;
        m_hi_prev = m_hi;
        if (e) begin
            m_pos = (m_pos + 1) % m_n;
            if (swap) m_n = m_req;
            m_hi = (m_pos < m_n / 2);
        end
        m_tick = last;
        m_ack  = swap;
        m_err  = 0;
        if (swap) m_has_req = 0;
        if (l) begin
            if (d < 2) begin
                m_err = 1;
            end else begin
                m_req     = d;
                m_has_req = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit exp_clk;
        exp_clk = m_hi;
`ifdef CLKDIV_ODD50_EN
        if (m_n % 2 == 1) exp_clk = m_hi | m_hi_prev;
`endif
        check("clkout", 32'(clkout), 32'(exp_clk));
        check("tick", 32'(tick), 32'(m_tick));
        check("cur_div", 32'(cur_div), 32'(m_n));
        check("pend", 32'(pend), 32'(m_has_req));
        check("div_ack", 32'(div_ack), 32'(m_ack));
        check("div_err", 32'(div_err), 32'(m_err));
    endtask

    task automatic step(input bit e, input bit l, input int d);
        @(negedge clkin);
        en     = e;
        div_ld = l;
        div_in = W'(d);
        @(posedge clkin);
        model_edge(e, l, d);
        #1 compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    task automatic async_reset();
        @(negedge clkin);
        en     = 1'b1;
        div_ld = 1'b0;
        #10 rst = 1'b1;
        #5;
        model_reset();
        compare_all();
        #25 rst = 1'b0;
        @(posedge clkin);
        model_edge(1'b1, 1'b0, 0);
        #1 compare_all();
    endtask

    function automatic int pick_div();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 8) return int'($urandom_range(0, 1));
        if (r < 95) return int'($urandom_range(2, 9));
        return int'($urandom_range(10, 40));
    endfunction

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        div_ld = 1'b0;
        div_in = '0;
        model_reset();
        #10 compare_all();
        #110 rst = 1'b0;
        @(posedge clkin);
        model_edge(1'b1, 1'b0, 0);
        #1 compare_all();

        run(6);
        step(1'b1, 1'b1, 4);
        run(9);
        step(1'b1, 1'b1, 6);
        run(14);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 7);
        run(20);
        step(1'b1, 1'b1, 7);
        run(16);
        step(1'b1, 1'b1, 3);
        run(12);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);
        run(6);
        step(1'b1, 1'b1, 9);
        async_reset();
        run(6);

        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                async_reset();
            end else begin
                step($urandom_range(0, 99) < 85,
                     $urandom_range(0, 99) < 10,
                     pick_div());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
